// File: rtl/rect_raster_pkg.sv
// Shared types and geometry defaults for the rectangle rasteriser and the VGA adapter.
package rect_raster_pkg;

  localparam int unsigned RR_X_W      = 9;
  localparam int unsigned RR_Y_W      = 8;
  localparam int unsigned RR_COLOR_W  = 3;
  localparam int unsigned RR_SCREEN_W = 320;
  localparam int unsigned RR_SCREEN_H = 240;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/rect_cursor.sv
// Rectangle cursor: holds the current position and end points and walks the
// rectangle row-major, skipping interior columns in outline mode.
// With RECT_RASTER_CLIP_EN defined, next_vis_c flags whether the next
// position lies inside the visible screen; otherwise it is always 1.
module rect_cursor
  import rect_raster_pkg::*;
#(
  parameter int unsigned X_W      = RR_X_W,
  parameter int unsigned Y_W      = RR_Y_W,
  parameter int unsigned SCREEN_W = RR_SCREEN_W,
  parameter int unsigned SCREEN_H = RR_SCREEN_H
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           load,
  input  logic           advance,
  input  logic           outline,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] len,
  input  logic [Y_W-1:0] wid,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last_c,
  output logic           next_vis_c
);

  // A screen larger than the coordinate range could never be clipped correctly.
  if (SCREEN_W > (1 << X_W) || SCREEN_H > (1 << Y_W)) begin : g_screen_too_big
    $error("rect_cursor: screen size exceeds coordinate field range");
  end

  logic [X_W-1:0] x0_q, xe_q;
  logic [Y_W-1:0] y0_q, ye_q;
  logic           outline_q;
  logic [X_W:0]   x_end_wide;
  logic [Y_W:0]   y_end_wide;
  logic [X_W-1:0] x_end, nx_c;
  logic [Y_W-1:0] y_end, ny_c;
  logic           interior_row;

  // End points computed one bit wider and saturated at the field maximum (len/wid >= 1 on load).
  assign x_end_wide = {1'b0, x0} + {1'b0, len} - (X_W+1)'(1);
  assign y_end_wide = {1'b0, y0} + {1'b0, wid} - (Y_W+1)'(1);
  assign x_end      = x_end_wide[X_W] ? '1 : x_end_wide[X_W-1:0];
  assign y_end      = y_end_wide[Y_W] ? '1 : y_end_wide[Y_W-1:0];

  assign interior_row = (cy != y0_q) && (cy != ye_q);
  assign last_c       = (cx == xe_q) && (cy == ye_q);

  // Next cursor position: load origin, step right, jump across an outline interior, or wrap to next row.
  always_comb begin
    nx_c = cx;
    ny_c = cy;
    if (load) begin
      nx_c = x0;
      ny_c = y0;
    end else if (advance) begin
      if (cx != xe_q) begin
        if (outline_q && interior_row && (cx == x0_q)) begin
          nx_c = xe_q;
        end else begin
          nx_c = cx + X_W'(1);
        end
      end else if (cy != ye_q) begin
        nx_c = x0_q;
        ny_c = cy + Y_W'(1);
      end
    end
  end

`ifdef RECT_RASTER_CLIP_EN
  assign next_vis_c = (32'(nx_c) < SCREEN_W) && (32'(ny_c) < SCREEN_H);
`else
  assign next_vis_c = 1'b1;
`endif

  // Cursor and latched geometry registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      cx        <= '0;
      cy        <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      outline_q <= 1'b0;
    end else begin
      cx <= nx_c;
      cy <= ny_c;
      if (load) begin
        x0_q      <= x0;
        y0_q      <= y0;
        xe_q      <= x_end;
        ye_q      <= y_end;
        outline_q <= outline;
      end
    end
  end

endmodule

// File: rtl/rect_raster.sv
// Rectangle rasteriser: latches a rectangle on start and emits its pixels over
// a valid/ready port, one per accepted handshake, then pulses done.
// Optional clipping against SCREEN_W/SCREEN_H is enabled by RECT_RASTER_CLIP_EN.
module rect_raster
  import rect_raster_pkg::*;
#(
  parameter int unsigned X_W      = RR_X_W,
  parameter int unsigned Y_W      = RR_Y_W,
  parameter int unsigned COLOR_W  = RR_COLOR_W,
  parameter int unsigned SCREEN_W = RR_SCREEN_W,
  parameter int unsigned SCREEN_H = RR_SCREEN_H
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     len,
  input  logic [Y_W-1:0]     wid,
  input  logic [COLOR_W-1:0] colour,
  input  logic               outline,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               done
);

  state_t state;
  logic   zero_size, load, advance, last_c, next_vis_c;

  assign zero_size = (len == '0) || (wid == '0);
  assign load      = (state == IDLE) && start && !zero_size;
  // Visible pixels wait for the handshake; clipped positions advance unconditionally.
  assign advance   = (state == DRAW) && (!pix_valid || pix_ready);

  rect_cursor #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_cursor (
    .clock      (clock),
    .rst        (rst),
    .load       (load),
    .advance    (advance),
    .outline    (outline),
    .x0         (x0),
    .y0         (y0),
    .len        (len),
    .wid        (wid),
    .cx         (pix_x),
    .cy         (pix_y),
    .last_c     (last_c),
    .next_vis_c (next_vis_c)
  );

  // Control FSM with registered status and pixel-valid outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_color <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pix_color <= colour;
            busy      <= 1'b1;
            if (zero_size) begin
              state     <= FINISH;
              done      <= 1'b1;
              pix_valid <= 1'b0;
            end else begin
              state     <= DRAW;
              pix_valid <= next_vis_c;
            end
          end
        end
        DRAW: begin
          if (advance) begin
            if (last_c) begin
              state     <= FINISH;
              done      <= 1'b1;
              pix_valid <= 1'b0;
            end else begin
              pix_valid <= next_vis_c;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          pix_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_raster.sv
// Directed self-checking bench for rect_raster.
module tb_rect_raster;

  logic       clock = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] x0;
  logic [7:0] y0;
  logic [8:0] len;
  logic [7:0] wid;
  logic [2:0] colour;
  logic       outline;
  logic       pix_valid;
  logic       pix_ready;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [2:0] pix_color;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_x[$];
  int exp_y[$];
  int ready_q[$];
  int exp_color;

  rect_raster dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .len       (len),
    .wid       (wid),
    .colour    (colour),
    .outline   (outline),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a rectangle with start high for one edge; returns 1 ns after the accepting edge.
  task automatic kick(input int x, input int y, input int l, input int w, input int c, input int o);
    x0      = 9'(x);
    y0      = 8'(y);
    len     = 9'(l);
    wid     = 8'(w);
    colour  = 3'(c);
    outline = 1'(o);
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Observe a drawing from the cycle after acceptance (cycle 1) until done.
  task automatic run(input string tag, input int exp_done);
    int         cyc     = 0;
    int         idx     = 0;
    bit         fin     = 1'b0;
    bit         stalled = 1'b0;
    logic [8:0] hx      = '0;
    logic [7:0] hy      = '0;
    logic [2:0] hc      = '0;
    while (!fin && cyc < 100) begin
      cyc++;
      pix_ready = (ready_q.size() > 0) ? 1'(ready_q.pop_front()) : 1'b1;
      if (done) begin
        fin = 1'b1;
        check({tag, "_done_cycle"}, cyc, exp_done);
        check({tag, "_done_busy"}, busy, 1);
        check({tag, "_done_valid"}, pix_valid, 0);
        check({tag, "_pixel_count"}, idx, exp_x.size());
      end else begin
        check({tag, "_busy"}, busy, 1);
        if (stalled) begin
          check({tag, "_stall_valid"}, pix_valid, 1);
          check({tag, "_stall_x"}, pix_x, hx);
          check({tag, "_stall_y"}, pix_y, hy);
          check({tag, "_stall_color"}, pix_color, hc);
        end
        if (pix_valid && pix_ready) begin
          if (idx < exp_x.size()) begin
            check($sformatf("%s_px%0d_x", tag, idx), pix_x, exp_x[idx]);
            check($sformatf("%s_px%0d_y", tag, idx), pix_y, exp_y[idx]);
            check($sformatf("%s_px%0d_color", tag, idx), pix_color, exp_color);
          end else begin
            check({tag, "_extra_pixel"}, idx, exp_x.size());
          end
          idx++;
        end
      end
      stalled = pix_valid && !pix_ready;
      hx = pix_x;
      hy = pix_y;
      hc = pix_color;
      step();
    end
    if (!fin) check({tag, "_timeout"}, cyc, exp_done);
    pix_ready = 1'b1;
    check({tag, "_after_done"}, done, 0);
    check({tag, "_after_busy"}, busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    x0        = '0;
    y0        = '0;
    len       = '0;
    wid       = '0;
    colour    = '0;
    outline   = 1'b0;
    pix_ready = 1'b1;
    repeat (2) step();

    check("reset_valid", pix_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_x", pix_x, 0);
    check("reset_y", pix_y, 0);
    check("reset_color", pix_color, 0);
    rst = 1'b0;
    step();

    // Fill 3x2 at (10,20): six pixels, done 7 cycles after the accepting edge.
    exp_x = '{10, 11, 12, 10, 11, 12};
    exp_y = '{20, 20, 20, 21, 21, 21};
    exp_color = 5;
    kick(10, 20, 3, 2, 5, 0);
    run("fill3x2", 7);

    // Outline 4x3 at origin: interior row emits only its two edge pixels.
    exp_x = '{0, 1, 2, 3, 0, 3, 0, 1, 2, 3};
    exp_y = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2};
    exp_color = 2;
    kick(0, 0, 4, 3, 2, 1);
    run("outline4x3", 11);

    // Backpressure on a 2x1 fill with ready pattern 0,0,1,0,1.
    exp_x = '{5, 6};
    exp_y = '{7, 7};
    exp_color = 6;
    ready_q = '{0, 0, 1, 0, 1};
    kick(5, 7, 2, 1, 6, 0);
    run("backpressure", 6);

    // Zero width: no pixels, done in the first cycle, busy for one cycle only.
    exp_x = {};
    exp_y = {};
    exp_color = 1;
    kick(40, 40, 0, 5, 1, 0);
    run("zero_len", 1);

    // Outline with a single column behaves like a fill.
    exp_x = '{9, 9, 9};
    exp_y = '{4, 5, 6};
    exp_color = 3;
    kick(9, 4, 1, 3, 3, 1);
    run("outline1x3", 4);

    // Reset on the third pixel of a 4x4 fill abandons the rectangle.
    exp_color = 4;
    kick(2, 3, 4, 4, 4, 0);
    check("rst_px0_x", pix_x, 2);
    check("rst_px0_y", pix_y, 3);
    step();
    check("rst_px1_x", pix_x, 3);
    step();
    check("rst_px2_x", pix_x, 4);
    check("rst_px2_valid", pix_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid", pix_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    step();
    check("rst_after_done", done, 0);
    check("rst_after_valid", pix_valid, 0);
    exp_x = '{100, 100};
    exp_y = '{50, 51};
    exp_color = 7;
    kick(100, 50, 1, 2, 7, 0);
    run("after_rst", 3);

    // Screen edge at x=318: clipped to two pixels only when clipping is built in.
`ifdef RECT_RASTER_CLIP_EN
    exp_x = '{318, 319};
    exp_y = '{0, 0};
`else
    exp_x = '{318, 319, 320, 321};
    exp_y = '{0, 0, 0, 0};
`endif
    exp_color = 5;
    kick(318, 0, 4, 1, 5, 0);
    run("screen_edge", 5);

    // Rectangle past the x field maximum saturates at 511 without wrapping.
`ifdef RECT_RASTER_CLIP_EN
    exp_x = {};
    exp_y = {};
`else
    exp_x = '{510, 511};
    exp_y = '{5, 5};
`endif
    exp_color = 1;
    kick(510, 5, 4, 1, 1, 0);
    run("x_saturate", 3);

    // Rectangle past the y field maximum saturates at 255 without wrapping.
`ifdef RECT_RASTER_CLIP_EN
    exp_x = {};
    exp_y = {};
`else
    exp_x = '{7, 7};
    exp_y = '{254, 255};
`endif
    exp_color = 2;
    kick(7, 254, 1, 3, 2, 1);
    run("y_saturate", 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
